// File: rtl/piano_light_pkg.sv
// Shared types and constants for the piano key-light scheduler.
// Holds note code widths, rest codes, state/source enums and counter sizing.
package piano_light_pkg;

    localparam int NOTE_W = 8;
    localparam logic [NOTE_W-1:0] REST_CODE_OFF  = 8'd0;
    localparam logic [NOTE_W-1:0] REST_CODE_STOP = 8'd99;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP
    } state_e;

    typedef enum logic {
        SRC_MAN,
        SRC_AUTO
    } src_e;

    // Counter only ever holds values up to max(hold,gap,1)-1.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = 1;
        if (hold > m) m = hold;
        if (gap > m) m = gap;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/piano_light_scheduler_arb.sv
// Two-way round-robin arbiter for the key-light scheduler.
// Ports: clk_i, rst_i, req_i[1:0] (bit0 manual), en_i, upd_i, upd_src_i, gnt_o[1:0].
module light_rr_arbiter2
    import piano_light_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       upd_i,
    input  src_e       upd_src_i,
    output logic [1:0] gnt_o
);

    src_e last_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (last_q == SRC_MAN) ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // Reset to autoplay so manual wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= SRC_AUTO;
        end else if (upd_i) begin
            last_q <= upd_src_i;
        end
    end

endmodule

// File: rtl/piano_light_scheduler.sv
// Shares the key lights between manual and autoplay sources with hold and gap timing.
// Ports: iClk, iReset, iMan*/oManReady, iAuto*/oAutoReady, oNote, oKeyLights, oBusy, oGrantSrc.
// Option: PIANO_MANUAL_PREEMPT_EN lets a manual note abort an autoplay note in ON.
module piano_light_scheduler
    import piano_light_pkg::*;
#(
    parameter int NUM_KEYS    = 21,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iManValid,
    input  logic [NOTE_W-1:0]   iManNote,
    output logic                oManReady,
    input  logic                iAutoValid,
    input  logic [NOTE_W-1:0]   iAutoNote,
    output logic                oAutoReady,
    output logic [NOTE_W-1:0]   oNote,
    output logic [NUM_KEYS-1:0] oKeyLights,
    output logic                oBusy,
    output logic                oGrantSrc
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int GAP_M1 = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_M1);

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [NOTE_W-1:0]   note_q;
    logic [NUM_KEYS-1:0] lights_q;
    src_e                src_q;

    logic [1:0]          gnt;
    logic                preempt;
    logic                man_xfer;
    logic                auto_xfer;
    logic                xfer;
    src_e                ld_src;
    logic [NOTE_W-1:0]   ld_code;
    logic [NOTE_W-1:0]   ld_note;
    logic [NUM_KEYS-1:0] ld_lights;

`ifdef PIANO_MANUAL_PREEMPT_EN
    assign preempt = (state_q == ON) && (src_q == SRC_AUTO);
`else
    assign preempt = 1'b0;
`endif

    light_rr_arbiter2 u_arb (
        .clk_i    (iClk),
        .rst_i    (iReset),
        .req_i    ({iAutoValid, iManValid}),
        .en_i     (state_q == IDLE),
        .upd_i    (xfer),
        .upd_src_i(ld_src),
        .gnt_o    (gnt)
    );

    // Readies are masked in reset so a pending request is never consumed.
    assign oManReady  = !iReset && (gnt[0] || (preempt && iManValid));
    assign oAutoReady = !iReset && gnt[1];

    assign man_xfer  = iManValid && oManReady;
    assign auto_xfer = iAutoValid && oAutoReady;
    assign xfer      = man_xfer || auto_xfer;
    assign ld_src    = man_xfer ? SRC_MAN : SRC_AUTO;
    assign ld_code   = man_xfer ? iManNote : iAutoNote;

    always_comb begin
        ld_note   = ld_code;
        ld_lights = '0;
        if (ld_code == REST_CODE_OFF || ld_code == REST_CODE_STOP) begin
            ld_note = '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                ld_lights[i] = (int'(ld_code) == i + 1);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            note_q   <= '0;
            lights_q <= '0;
            src_q    <= SRC_MAN;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_q  <= ON;
                        cnt_q    <= HOLD_LOAD;
                        note_q   <= ld_note;
                        lights_q <= ld_lights;
                        src_q    <= ld_src;
                    end
                end
                ON: begin
                    if (man_xfer) begin
                        // Manual preemption restarts the hold with no gap.
                        cnt_q    <= HOLD_LOAD;
                        note_q   <= ld_note;
                        lights_q <= ld_lights;
                        src_q    <= SRC_MAN;
                    end else if (cnt_q == '0) begin
                        note_q   <= '0;
                        lights_q <= '0;
                        cnt_q    <= GAP_LOAD;
                        state_q  <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oNote      = note_q;
    assign oKeyLights = lights_q;
    assign oBusy      = (state_q != IDLE);
    assign oGrantSrc  = src_q;

endmodule

// File: tb/tb_piano_light_scheduler.sv
// Scoreboard bench for piano_light_scheduler (default HOLD=4, GAP=2, 21 keys).
// Honors PIANO_MANUAL_PREEMPT_EN for the preemption scenario.
module tb_piano_light_scheduler;

    localparam int NK   = 21;
    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic          iClk = 1'b0;
    logic          iReset;
    logic          iManValid;
    logic [7:0]    iManNote;
    logic          oManReady;
    logic          iAutoValid;
    logic [7:0]    iAutoNote;
    logic          oAutoReady;
    logic [7:0]    oNote;
    logic [NK-1:0] oKeyLights;
    logic          oBusy;
    logic          oGrantSrc;

    piano_light_scheduler #(
        .NUM_KEYS   (NK),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP)
    ) dut (
        .iClk      (iClk),
        .iReset    (iReset),
        .iManValid (iManValid),
        .iManNote  (iManNote),
        .oManReady (oManReady),
        .iAutoValid(iAutoValid),
        .iAutoNote (iAutoNote),
        .oAutoReady(oAutoReady),
        .oNote     (oNote),
        .oKeyLights(oKeyLights),
        .oBusy     (oBusy),
        .oGrantSrc (oGrantSrc)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [7:0]    note;
        logic [NK-1:0] lights;
        logic          src;
    } exp_t;

    exp_t sb[$];
    bit   pend;
    int   n_chk;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic src, input logic [7:0] n);
        exp_t e;
        e.src    = src;
        e.note   = (n == 8'd0 || n == 8'd99) ? 8'd0 : n;
        e.lights = '0;
        if (n >= 8'd1 && int'(n) <= NK) e.lights = NK'(1) << (int'(n) - 1);
        return e;
    endfunction

    // Transfers seen on a falling edge are checked on the next falling edge.
    always @(negedge iClk) begin
        exp_t e;
        if (pend) begin
            pend = 1'b0;
            chk("sb_empty", 32'(sb.size() == 0), 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_note", 32'(oNote), 32'(e.note));
                chk("sb_lights", 32'(oKeyLights), 32'(e.lights));
                chk("sb_src", 32'(oGrantSrc), 32'(e.src));
            end
        end
        if (!iReset && iManValid && oManReady) begin
            sb.push_back(model(1'b0, iManNote));
            pend = 1'b1;
        end else if (!iReset && iAutoValid && oAutoReady) begin
            sb.push_back(model(1'b1, iAutoNote));
            pend = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic send(input logic src, input logic [7:0] n);
        bit got;
        got = 1'b0;
        if (src) begin
            iAutoValid = 1'b1;
            iAutoNote  = n;
        end else begin
            iManValid = 1'b1;
            iManNote  = n;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge iClk);
            got = src ? oAutoReady : oManReady;
            cyc();
        end
        chk("send_tmo", 32'(got), 32'd1);
        if (src) iAutoValid = 1'b0;
        else iManValid = 1'b0;
    endtask

    // Called in the first lit cycle; ends in the first cycle after the window.
    task automatic window(input logic [7:0] n, input logic [NK-1:0] l);
        for (int k = 1; k <= HOLD + GAP; k++) begin
            @(negedge iClk);
            if (k <= HOLD) begin
                chk("win_note", 32'(oNote), 32'(n));
                chk("win_lights", 32'(oKeyLights), 32'(l));
            end else begin
                chk("gap_note", 32'(oNote), 32'd0);
                chk("gap_lights", 32'(oKeyLights), 32'd0);
            end
            chk("win_busy", 32'(oBusy), 32'd1);
            chk("win_mrdy", 32'(oManReady), 32'd0);
            chk("win_ardy", 32'(oAutoReady), 32'd0);
            cyc();
        end
        @(negedge iClk);
        chk("end_busy", 32'(oBusy), 32'd0);
        chk("end_mrdy", 32'(oManReady), 32'(iManValid));
        cyc();
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge iClk);
            got = !oBusy;
            cyc();
        end
        chk("idle_tmo", 32'(got), 32'd1);
    endtask

    initial begin
        bit got;
        iReset     = 1'b1;
        iManValid  = 1'b0;
        iManNote   = '0;
        iAutoValid = 1'b0;
        iAutoNote  = '0;
        repeat (3) cyc();
        @(negedge iClk);
        chk("rst_note", 32'(oNote), 32'd0);
        chk("rst_lights", 32'(oKeyLights), 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_src", 32'(oGrantSrc), 32'd0);
        cyc();
        iReset = 1'b0;
        cyc();

        // Manual 5 alone, then a back-to-back repeat held across the window.
        send(1'b0, 8'd5);
        iManValid = 1'b1;
        iManNote  = 8'd5;
        window(8'd5, NK'(1) << 4);
        iManValid = 1'b0;
        window(8'd5, NK'(1) << 4);

        // Both valid after reset: manual, autoplay, manual.
        iReset = 1'b1;
        cyc();
        iReset     = 1'b0;
        iManValid  = 1'b1;
        iManNote   = 8'd3;
        iAutoValid = 1'b1;
        iAutoNote  = 8'd7;
        for (int g = 0; g < 3; g++) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge iClk);
                got = oManReady || oAutoReady;
                if (got) begin
                    chk("rr_onehot", 32'(oManReady && oAutoReady), 32'd0);
                    chk("rr_src", 32'(oAutoReady), 32'(g % 2));
                end
                cyc();
            end
            chk("rr_tmo", 32'(got), 32'd1);
        end
        iManValid  = 1'b0;
        iAutoValid = 1'b0;
        wait_idle();

        // Rest codes and out-of-range pass-through.
        send(1'b1, 8'd0);
        window(8'd0, '0);
        send(1'b1, 8'd99);
        window(8'd0, '0);
        send(1'b1, 8'd30);
        window(8'd30, '0);
        send(1'b1, 8'd21);
        window(8'd21, NK'(1) << 20);

        // Reset in ON cycle 2 with a manual request pending.
        send(1'b1, 8'd9);
        cyc();
        iReset    = 1'b1;
        iManValid = 1'b1;
        iManNote  = 8'd4;
        @(negedge iClk);
        chk("mid_rst_rdy", 32'(oManReady), 32'd0);
        chk("mid_rst_lit", 32'(oNote), 32'd9);
        cyc();
        iReset = 1'b0;
        @(negedge iClk);
        chk("post_rst_note", 32'(oNote), 32'd0);
        chk("post_rst_busy", 32'(oBusy), 32'd0);
        chk("post_rst_rdy", 32'(oManReady), 32'd1);
        cyc();
        iManValid = 1'b0;
        window(8'd4, NK'(1) << 3);

        // Manual request while autoplay 7 is lit.
        send(1'b1, 8'd7);
        iManValid = 1'b1;
        iManNote  = 8'd2;
`ifdef PIANO_MANUAL_PREEMPT_EN
        @(negedge iClk);
        chk("pre_rdy", 32'(oManReady), 32'd1);
        cyc();
        iManValid = 1'b0;
        for (int k = 0; k < HOLD; k++) begin
            @(negedge iClk);
            chk("pre_note", 32'(oNote), 32'd2);
            chk("pre_src", 32'(oGrantSrc), 32'd0);
            cyc();
        end
        @(negedge iClk);
        chk("pre_dark", 32'(oNote), 32'd0);
        cyc();
        wait_idle();
`else
        for (int k = 0; k < HOLD + GAP; k++) begin
            @(negedge iClk);
            chk("nopre_rdy", 32'(oManReady), 32'd0);
            cyc();
        end
        @(negedge iClk);
        chk("nopre_idle_rdy", 32'(oManReady), 32'd1);
        cyc();
        iManValid = 1'b0;
        window(8'd2, NK'(1) << 1);
`endif

        @(negedge iClk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
